// File: rtl/mac_out_fifo.sv
// Output queue behind MAC stage 5: optional ReLU, end-of-tile tagging, and a
// registered inhibit that freezes stages 1-5 while the queue is full.
module mac_out_fifo #(
    parameter int DEPTH  = 4,
    parameter int CH_NUM = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_clr,
    input  logic                     i_relu,
    input  logic                     i_valid,
    input  logic [15:0]              i_conv,
    output logic                     o_inhibit,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [15:0]              o_data,
    output logic                     o_last,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [TW-1:0] LAST_IDX = TW'(CH_NUM - 1);

    logic [16:0]   mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [TW-1:0] tile_q, tile_d;
    logic          inhibit_q, inhibit_d;

    logic          push, pop, is_last;
    logic [15:0]   wr_data;

    // Handshake: the head transfers on a cycle where o_valid & i_ready are both
    // high; o_data/o_last are held while o_valid=1 and i_ready=0. Upstream is
    // throttled by o_inhibit, so a word offered while inhibited is not taken.
    assign push    = i_valid & ~inhibit_q & ~i_clr;
    assign pop     = o_valid & i_ready & ~i_clr;
    assign is_last = (tile_q == LAST_IDX);
    assign wr_data = (i_relu & i_conv[15]) ? 16'h0000 : i_conv;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        tile_d   = tile_q;
        if (i_clr) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            tile_d   = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                tile_d   = is_last ? '0 : tile_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
        inhibit_d = (count_d == FULL_CNT);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            tile_q    <= '0;
            inhibit_q <= 1'b0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            tile_q    <= tile_d;
            inhibit_q <= inhibit_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {is_last, wr_data};
        end
    end

    assign o_valid   = (count_q != '0);
    assign o_data    = o_valid ? mem_q[rd_ptr_q][15:0] : 16'h0000;
    assign o_last    = o_valid ? mem_q[rd_ptr_q][16] : 1'b0;
    assign o_level   = count_q;
    assign o_inhibit = inhibit_q;

endmodule
